// File: rtl/stochastic_to_binary_converter_pkg.sv
// Shared definitions for the SBS decoder: FSM state encoding and default sizing.
// The SNG and the benches reuse the same defaults.
package stochastic_to_binary_converter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    localparam int DEFAULT_N_BITS = 4;
    // One full period of an N_BITS-wide maximal LFSR.
    localparam int DEFAULT_WINDOW = (1 << DEFAULT_N_BITS) - 1;

endpackage

// File: rtl/stochastic_to_binary_converter_window_counter.sv
// Counts accepted SBS samples and flags the one that closes the window.
// Wraps to zero on that sample so the next window can start on the following edge.
module sbs_window_counter
    import stochastic_to_binary_converter_pkg::*;
#(
    parameter int N_BITS = DEFAULT_N_BITS,
    parameter int WINDOW = DEFAULT_WINDOW
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [N_BITS-1:0] LAST_COUNT = N_BITS'(WINDOW - 1);
    localparam logic [N_BITS-1:0] ONE        = N_BITS'(1);

    logic [N_BITS-1:0] count;

    assign last = en && (count == LAST_COUNT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + ONE;
        end
    end

endmodule

// File: rtl/stochastic_to_binary_converter.sv
// Recovers a binary value from an SBS stream by counting ones over WINDOW valid samples.
// Supports single-shot and gap-free continuous conversion; all outputs are registered.
module stochastic_to_binary_converter
    import stochastic_to_binary_converter_pkg::*;
#(
    parameter int N_BITS = DEFAULT_N_BITS,
    parameter int WINDOW = DEFAULT_WINDOW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              sbs_in,
    input  logic              sbs_valid,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] result
);

    generate
        if (WINDOW < 1 || WINDOW > (1 << N_BITS) - 1) begin : g_bad_window
            $error("WINDOW must be in 1 .. 2**N_BITS-1");
        end
    endgenerate

    state_t            state;
    state_t            next_state;
    logic [N_BITS-1:0] acc;
    logic              sample_en;
    logic              begin_conv;
    logic              last;
    logic              window_end;

    assign sample_en  = (state == ST_ACCUM) && sbs_valid;
    assign begin_conv = (state == ST_IDLE) && start;
    assign window_end = sample_en && last;
    assign busy       = (state == ST_ACCUM);

    sbs_window_counter #(
        .N_BITS (N_BITS),
        .WINDOW (WINDOW)
    ) u_window_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (begin_conv),
        .en   (sample_en),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_ACCUM;
            ST_ACCUM: if (window_end && !cont) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // The closing sample is folded straight into result; acc restarts for the next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= window_end;
            if (begin_conv || window_end) begin
                acc <= '0;
            end else if (sample_en) begin
                acc <= acc + N_BITS'(sbs_in);
            end
            if (window_end) begin
                result <= acc + N_BITS'(sbs_in);
            end
        end
    end

endmodule

// File: tb/tb_stochastic_to_binary_converter.sv
// Directed bench for stochastic_to_binary_converter: a window-of-samples model checked
// every cycle, plus literal expectations for each scenario.
module tb_stochastic_to_binary_converter;

    localparam int N_BITS = 4;
    localparam int WINDOW = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              cont;
    logic              sbs_in;
    logic              sbs_valid;
    logic              busy;
    logic              done;
    logic [N_BITS-1:0] result;

    stochastic_to_binary_converter #(
        .N_BITS (N_BITS),
        .WINDOW (WINDOW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .sbs_in    (sbs_in),
        .sbs_valid (sbs_valid),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Reference model: collect the valid samples of the open window and sum them when full.
    bit m_ready  = 1'b0;
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_result = 0;
    bit win_q[$];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_ready  = 1'b1;
                m_active = 1'b0;
                m_done   = 1'b0;
                m_result = 0;
                win_q.delete();
            end else begin
                m_done = 1'b0;
                if (!m_active) begin
                    if (start) begin
                        m_active = 1'b1;
                        win_q.delete();
                    end
                end else if (sbs_valid) begin
                    win_q.push_back(sbs_in);
                    if (win_q.size() == WINDOW) begin
                        m_result = 0;
                        foreach (win_q[i]) m_result += int'(win_q[i]);
                        m_done   = 1'b1;
                        m_active = cont;
                        win_q.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("model_busy", 32'(busy), 32'(m_active));
            check("model_done", 32'(done), 32'(m_done));
            check("model_result", 32'(result), 32'(m_result));
            if (done === 1'b1) done_q.push_back(cyc);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(output int c_start);
        start = 1'b1;
        tick();
        start = 1'b0;
        c_start = cyc;
    endtask

    // Samples go out MSB first; stall_mask[i] inserts one invalid cycle after sample i.
    task automatic feed(input logic [14:0] pat, input int n, input logic [14:0] stall_mask,
                        input logic last_cont);
        for (int i = 0; i < n; i++) begin
            sbs_in    = pat[14-i];
            sbs_valid = 1'b1;
            if (i == n - 1) cont = last_cont;
            tick();
            if (stall_mask[i] && i != n - 1) begin
                sbs_valid = 1'b0;
                sbs_in    = 1'b1;
                tick();
            end
        end
        sbs_valid = 1'b0;
        sbs_in    = 1'b0;
    endtask

    initial begin
        logic [14:0] p7, p5, p4, ones, zeros, stalls;
        int          c_start;
        int          n_stall;

        p7    = 15'b101010101010100;
        p5    = 15'b100100100100100;
        p4    = 15'b100010001000100;
        ones  = 15'h7FFF;
        zeros = 15'h0000;

        rst = 1'b1; start = 1'b0; cont = 1'b0; sbs_in = 1'b0; sbs_valid = 1'b0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_result", 32'(result), 0);
        rst = 1'b0;
        tick();

        // Single conversion of seven ones.
        done_q.delete();
        do_start(c_start);
        feed(p7, 15, 15'h0, 1'b0);
        check("t1_done", 32'(done), 1);
        check("t1_result", 32'(result), 7);
        check("t1_busy", 32'(busy), 0);
        tick();
        check("t1_done_once", 32'(done_q.size()), 1);
        if (done_q.size() == 1) check("t1_latency", 32'(done_q[0] - c_start), 15);

        // Saturated windows.
        do_start(c_start);
        feed(ones, 15, 15'h0, 1'b0);
        check("t2_ones", 32'(result), 15);
        tick();
        do_start(c_start);
        feed(zeros, 15, 15'h0, 1'b0);
        check("t2_zeros", 32'(result), 0);
        tick();

        // Three stall cycles at random gaps; garbage sbs_in during stalls must be ignored.
        stalls  = '0;
        n_stall = 0;
        while (n_stall < 3) begin
            int pos;
            pos = int'($urandom_range(0, 13));
            if (!stalls[pos]) begin
                stalls[pos] = 1'b1;
                n_stall++;
            end
        end
        done_q.delete();
        do_start(c_start);
        feed(p7, 15, stalls, 1'b0);
        check("t3_result", 32'(result), 7);
        tick();
        check("t3_done_once", 32'(done_q.size()), 1);
        if (done_q.size() == 1) check("t3_latency", 32'(done_q[0] - c_start), 18);

        // Back-to-back continuous windows.
        done_q.delete();
        cont = 1'b1;
        do_start(c_start);
        feed(p5, 15, 15'h0, 1'b1);
        check("t4_result_a", 32'(result), 5);
        check("t4_busy_a", 32'(busy), 1);
        feed(p4, 15, 15'h0, 1'b0);
        check("t4_result_b", 32'(result), 4);
        check("t4_busy_b", 32'(busy), 0);
        cont = 1'b0;
        tick();
        check("t4_done_count", 32'(done_q.size()), 2);
        if (done_q.size() == 2) begin
            check("t4_first", 32'(done_q[0] - c_start), 15);
            check("t4_spacing", 32'(done_q[1] - done_q[0]), 15);
        end

        // Reset after eight samples discards the partial window.
        done_q.delete();
        do_start(c_start);
        feed(p7, 8, 15'h0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_result", 32'(result), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        tick();
        tick();
        check("t5_no_done", 32'(done_q.size()), 0);
        do_start(c_start);
        feed(p7, 15, 15'h0, 1'b0);
        check("t5_redo", 32'(result), 7);
        tick();

        // start held through the whole window, including the done edge.
        done_q.delete();
        do_start(c_start);
        start = 1'b1;
        feed(p7, 15, 15'h0, 1'b0);
        start = 1'b0;
        check("t6_result", 32'(result), 7);
        check("t6_busy_end", 32'(busy), 0);
        tick();
        tick();
        tick();
        check("t6_stay_idle", 32'(busy), 0);
        check("t6_done_once", 32'(done_q.size()), 1);
        if (done_q.size() == 1) check("t6_latency", 32'(done_q[0] - c_start), 15);
        do_start(c_start);
        feed(p4, 15, 15'h0, 1'b0);
        check("t6_next", 32'(result), 4);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stochastic_to_binary_converter.md
Name: stochastic_to_binary_converter

Overview:
Decoder at the receiving end of the stochastic number generator's SBS stream.
- Counts ones in a fixed window of valid SBS samples and reports the recovered binary value (ones count, 0..WINDOW).
- Sits downstream of stochastic arithmetic (AND/MUX of SBS streams) so results can be read back as binary for checking and for display.

Parameters:
N_BITS, 4, width of recovered value; matches the SNG comparator/LFSR width.
WINDOW, 15, valid samples per conversion; must satisfy 1 <= WINDOW <= 2**N_BITS - 1 (elaboration-time error otherwise); 15 = full period of the 4-bit LFSR.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a conversion; sampled only in IDLE.
cont  input  1  continuous mode; sampled at the end of each window.
sbs_in  input  1  stochastic bit-stream sample.
sbs_valid  input  1  sbs_in is valid this cycle; low = stall, sample ignored.
busy  output  1  high while in ACCUM.
done  output  1  one-cycle pulse when result is updated.
result  output  N_BITS  ones count of the last completed window; held until the next done.

Behaviour:
- Reset: synchronous, active-high, checked on every rising edge.
  - Takes priority over all inputs, including mid-window.
  - Clears state to IDLE and zeroes the accumulator, the sample counter, result, done and busy.
  - A partially accumulated window is discarded; result is not updated from it.
- States: IDLE, ACCUM. Encoding is 1 bit (IDLE=0, ACCUM=1).
- IDLE:
  - busy=0.
  - start=1 → ACCUM next cycle, with accumulator=0 and sample counter=0.
  - sbs_in and sbs_valid are ignored in IDLE, including in the cycle where start is sampled. Sampling begins the cycle after start.
- ACCUM:
  - busy=1.
  - On each edge with sbs_valid=1: accumulator += sbs_in, sample counter += 1.
  - sbs_valid=0: no change (stall of any length allowed).
  - start is ignored while in ACCUM.
- Window end: the edge that accepts the WINDOW-th valid sample.
  - result <= accumulator + sbs_in, as one combined update (no extra cycle).
  - done=1 for exactly the following cycle.
  - Accumulator and counter clear to 0.
  - cont=1 at that edge: stay in ACCUM. The next valid sample (possibly the very next cycle) counts toward the new window, so there are no dead cycles between windows.
  - cont=0 at that edge: go to IDLE, with busy=0 in the same cycle done=1.
- Latency: done rises one cycle after the edge that samples the last valid bit.
- Arithmetic:
  - Accumulator and counter are N_BITS wide, unsigned.
  - No overflow is possible because WINDOW <= 2**N_BITS - 1.
  - The counter compares against WINDOW-1 on valid samples; it does not wrap.
- Outputs are all registered; there are no combinational paths from inputs to outputs.
- Simultaneous events:
  - rst + anything → reset wins.
  - start asserted in the same cycle as done (with cont=0): ignored, because the FSM is leaving ACCUM. start must be reasserted in IDLE.

Decomposition:
- Shared include/package: state encoding constants (ST_IDLE, ST_ACCUM) and a default WINDOW localparam derived from N_BITS, for reuse by the SNG and the benches.
- One natural sub-module, sbs_window_counter. It holds the sample counter plus the last-sample flag (inputs clk, rst, clr, en; output last).
- The top level holds the FSM, the accumulator and the result/done registers.

Test Plan:
1. rst=1 for 2 cycles then release; drive start=1 for one cycle. Feed 15 valid samples containing 7 ones (the SNG encoding of X1=7). Required: done pulses once, result=7, busy falls with done.
2. All-ones window → result=15; all-zeros window → result=0; no wrap of result or accumulator.
3. Stall: same 7-ones stream with sbs_valid deasserted for 3 random cycles between samples. Required: result=7, and done is delayed by exactly the number of stall cycles.
4. cont=1 with back-to-back windows of 5 ones then 4 ones (X2=5, X3=4), valid every cycle. Required: done pulses exactly 15 cycles apart, result=5 then 4, busy stays high throughout.
5. Reset mid-window after 8 samples. Required: result=0, busy=0, no done pulse. A subsequent full conversion of 7 ones gives result=7 (no residue from the aborted window).
6. start pulsed while busy, and in the done cycle with cont=0. Required: the current conversion completes unaffected, and no new conversion starts until start is seen in IDLE.
